// File: rtl/frontier_fetch_scheduler_if.sv
// Frontier fetch scheduler bus bundle.
// Carries the frontier-ID input stream (vid_*) and the node-fetcher request
// channel (node_addr / num_nodes / fetch_start / fetch_done).
//   master : the scheduler side (consumes IDs, issues fetch requests)
//   slave  : the environment side (frontier queue + node fetcher)
interface frontier_fetch_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 32
) ();
    logic [ID_WIDTH-1:0]   vid_data;
    logic                  vid_valid;
    logic                  vid_last;
    logic                  vid_ready;
    logic [ADDR_WIDTH-1:0] node_addr;
    logic [7:0]            num_nodes;
    logic                  fetch_start;
    logic                  fetch_done;

    modport master (
        input  vid_data, vid_valid, vid_last, fetch_done,
        output vid_ready, node_addr, num_nodes, fetch_start
    );

    modport slave (
        output vid_data, vid_valid, vid_last, fetch_done,
        input  vid_ready, node_addr, num_nodes, fetch_start
    );
endinterface

// File: rtl/frontier_fetch_scheduler.sv
// Frontier fetch scheduler.
// Coalesces runs of consecutive frontier vertex IDs into node-record bursts
// (bounded by MAX_BURST and never crossing a 4 KB page) and issues them one at
// a time to the node fetcher, flagging the end of each frontier level.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   base_addr      : node array base byte address (stable while busy)
//   bus            : ID stream in + fetch request/completion (master modport)
//   busy           : high whenever the scheduler is not IDLE
//   level_done     : one-cycle pulse when the burst holding vid_last completes
//   bursts_issued  : wrapping count of issued fetches
module frontier_fetch_scheduler #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = 32,
    parameter int unsigned NODE_BYTES_LOG2 = 3,
    parameter int unsigned MAX_BURST       = 16,
    parameter int unsigned FLUSH_TIMEOUT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    frontier_fetch_scheduler_if.master    bus,
    output logic                          busy,
    output logic                          level_done,
    output logic [15:0]                   bursts_issued
);

    localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);
    localparam int unsigned IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_ISSUE,
        S_WAIT_ARM,
        S_WAIT
    } state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   start_id_q, start_id_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] node_addr_q, node_addr_d;
    logic [7:0]            num_nodes_q, num_nodes_d;
    logic                  fetch_start_q, fetch_start_d;
    logic                  level_done_q, level_done_d;
    logic [15:0]           bursts_q, bursts_d;
    logic                  vid_ready_c;
    logic                  coalesce_c;
    logic [ADDR_WIDTH-1:0] vid_addr_c;
    logic [ID_WIDTH-1:0]   next_id_c;

    // Byte address of a node record, truncated to ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [ID_WIDTH-1:0]   id
    );
        return base + (ADDR_WIDTH'(id) << NODE_BYTES_LOG2);
    endfunction

    // Coalescing test for the ID currently on the input.
    always_comb begin
        vid_addr_c = addr_of(base_addr, bus.vid_data);
        next_id_c  = start_id_q + ID_WIDTH'(count_q);
        coalesce_c = (bus.vid_data == next_id_c)
                  && (count_q < CNT_W'(MAX_BURST))
                  && (vid_addr_c[11:0] != 12'd0);
    end

    // Next-state and datapath.
    always_comb begin
        state_d       = state_q;
        start_id_d    = start_id_q;
        count_d       = count_q;
        idle_d        = idle_q;
        last_d        = last_q;
        node_addr_d   = node_addr_q;
        num_nodes_d   = num_nodes_q;
        fetch_start_d = 1'b0;
        level_done_d  = 1'b0;
        bursts_d      = bursts_q;
        vid_ready_c   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                vid_ready_c = 1'b1;
                if (bus.vid_valid) begin
                    start_id_d = bus.vid_data;
                    count_d    = CNT_W'(1);
                    last_d     = bus.vid_last;
                    idle_d     = '0;
                    state_d    = (bus.vid_last || MAX_BURST == 1) ? S_ISSUE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.vid_valid) begin
                    if (coalesce_c) begin
                        vid_ready_c = 1'b1;
                        count_d     = count_q + CNT_W'(1);
                        idle_d      = '0;
                        last_d      = bus.vid_last;
                        if (bus.vid_last || (count_q + CNT_W'(1) == CNT_W'(MAX_BURST))) begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        // Held ID stays on the input; it starts the next burst.
                        state_d = S_ISSUE;
                    end
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                    if (idle_q + IDLE_W'(1) >= IDLE_W'(FLUSH_TIMEOUT)) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_ARM;
            end
            S_WAIT_ARM: begin
                // fetch_done may still be the sticky level from the prior burst.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.fetch_done) begin
                    level_done_d = last_q;
                    last_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Request outputs are loaded on entry to ISSUE so they are valid with the pulse.
        if (state_d == S_ISSUE) begin
            fetch_start_d = 1'b1;
            node_addr_d   = addr_of(base_addr, start_id_d);
            num_nodes_d   = 8'(count_d - CNT_W'(1));
            bursts_d      = bursts_q + 16'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            start_id_q    <= '0;
            count_q       <= '0;
            idle_q        <= '0;
            last_q        <= 1'b0;
            node_addr_q   <= '0;
            num_nodes_q   <= '0;
            fetch_start_q <= 1'b0;
            level_done_q  <= 1'b0;
            bursts_q      <= '0;
        end else begin
            state_q       <= state_d;
            start_id_q    <= start_id_d;
            count_q       <= count_d;
            idle_q        <= idle_d;
            last_q        <= last_d;
            node_addr_q   <= node_addr_d;
            num_nodes_q   <= num_nodes_d;
            fetch_start_q <= fetch_start_d;
            level_done_q  <= level_done_d;
            bursts_q      <= bursts_d;
        end
    end

    assign bus.vid_ready   = vid_ready_c & ~rst;
    assign bus.node_addr   = node_addr_q;
    assign bus.num_nodes   = num_nodes_q;
    assign bus.fetch_start = fetch_start_q;
    assign busy            = (state_q != S_IDLE);
    assign level_done      = level_done_q;
    assign bursts_issued   = bursts_q;

endmodule
